complete_arbiter: RTL and testbench

- Arbitrates completion results from NUM_REQ functional-unit requesters onto NUM_SLOT completion/broadcast slots per cycle. Slots are filled round-robin.
- Sits between the execution units and the ROB complete ports. It also feeds the wakeup broadcast.
- Each requester has a small FIFO, so a unit finishing while slots are busy is back-pressured through req_ready instead of losing its result.

---
 rtl/complete_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_complete_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complete_arbiter.sv
// complete_arbiter
//   Collects completion results from NUM_REQ functional units (ALU0..2, LSU)
//   into small per-unit FIFOs and drains up to NUM_SLOT of them per cycle onto
//   the ROB complete / wakeup broadcast slots. FIFO heads are scanned
//   round-robin starting at rr_ptr. A unit gets at most one slot per cycle.
//
// Ports
//   clk, rstn     clock, asynchronous active-low reset
//   flush         synchronous clear of FIFOs, outputs and rr_ptr
//   hold          ROB stall: cmp_* and FIFO heads frozen, pushes still land
//   req_valid     per-unit result valid      req_ready  per-unit FIFO not full
//   req_pc/rd/data  per-unit payload, unit r at [r*W +: W]
//   cmp_valid/pc/rd/data/src  registered completion slots
//   overflow_err  sticky, set when a unit pushes into a full FIFO
module complete_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_SLOT = 2,
  parameter int DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   hold,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_pc,
  input  logic [NUM_REQ*6-1:0]   req_rd,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic [NUM_SLOT-1:0]    cmp_valid,
  output logic [NUM_SLOT*32-1:0] cmp_pc,
  output logic [NUM_SLOT*6-1:0]  cmp_rd,
  output logic [NUM_SLOT*32-1:0] cmp_data,
  output logic [NUM_SLOT*2-1:0]  cmp_src,
  output logic                   overflow_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  // FIFO storage and pointers
  logic [31:0]      pc_mem_q   [NUM_REQ][DEPTH];
  logic [31:0]      pc_mem_d   [NUM_REQ][DEPTH];
  logic [5:0]       rd_mem_q   [NUM_REQ][DEPTH];
  logic [5:0]       rd_mem_d   [NUM_REQ][DEPTH];
  logic [31:0]      data_mem_q [NUM_REQ][DEPTH];
  logic [31:0]      data_mem_d [NUM_REQ][DEPTH];
  logic [AW-1:0]    wr_ptr_q   [NUM_REQ];
  logic [AW-1:0]    wr_ptr_d   [NUM_REQ];
  logic [AW-1:0]    rd_ptr_q   [NUM_REQ];
  logic [AW-1:0]    rd_ptr_d   [NUM_REQ];
  logic [CW-1:0]    cnt_q      [NUM_REQ];
  logic [CW-1:0]    cnt_d      [NUM_REQ];

  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_SLOT-1:0]    cmp_valid_q, cmp_valid_d;
  logic [NUM_SLOT*32-1:0] cmp_pc_q, cmp_pc_d;
  logic [NUM_SLOT*6-1:0]  cmp_rd_q, cmp_rd_d;
  logic [NUM_SLOT*32-1:0] cmp_data_q, cmp_data_d;
  logic [NUM_SLOT*2-1:0]  cmp_src_q, cmp_src_d;
  logic                   overflow_q, overflow_d;

  logic [NUM_REQ-1:0]  not_empty;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  push;
  logic [NUM_REQ-1:0]  pop;
  logic [PTR_W-1:0]    scan_idx [NUM_REQ];
  logic [PTR_W-1:0]    slot_src [NUM_SLOT];
  logic [NUM_SLOT-1:0] slot_hit;
  logic [PTR_W-1:0]    last_idx;

  // Ready depends only on the registered count: a pop in the same cycle does
  // not open up space until the next cycle.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      not_empty[r] = (cnt_q[r] != '0);
      req_ready[r] = (cnt_q[r] < CW'(DEPTH));
      scan_idx[r]  = PTR_W'((int'(rr_ptr_q) + r) % NUM_REQ);
    end
  end

  // Slot s takes the first non-empty head in rotated order that no earlier
  // slot already took.
  always_comb begin
    grant    = '0;
    slot_hit = '0;
    last_idx = rr_ptr_q;
    for (int s = 0; s < NUM_SLOT; s++) begin
      slot_src[s] = '0;
    end
    for (int s = 0; s < NUM_SLOT; s++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!slot_hit[s] && not_empty[scan_idx[k]] && !grant[scan_idx[k]]) begin
          grant[scan_idx[k]] = 1'b1;
          slot_hit[s]        = 1'b1;
          slot_src[s]        = scan_idx[k];
          last_idx           = scan_idx[k];
        end
      end
    end
  end

  // FIFO next state
  always_comb begin
    pc_mem_d   = pc_mem_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    push       = '0;
    pop        = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      push[r] = req_valid[r] & req_ready[r] & ~flush;
      pop[r]  = grant[r] & ~hold & ~flush;
      if (push[r]) begin
        pc_mem_d[r][wr_ptr_q[r]]   = req_pc[r*32 +: 32];
        rd_mem_d[r][wr_ptr_q[r]]   = req_rd[r*6 +: 6];
        data_mem_d[r][wr_ptr_q[r]] = req_data[r*32 +: 32];
        wr_ptr_d[r]                = wr_ptr_q[r] + AW'(1);
      end
      if (pop[r]) begin
        rd_ptr_d[r] = rd_ptr_q[r] + AW'(1);
      end
      cnt_d[r] = cnt_q[r] + CW'(push[r]) - CW'(pop[r]);
      if (flush) begin
        wr_ptr_d[r] = '0;
        rd_ptr_d[r] = '0;
        cnt_d[r]    = '0;
      end
    end
  end

  // Completion slots, round-robin pointer, sticky overflow
  always_comb begin
    cmp_valid_d = cmp_valid_q;
    cmp_pc_d    = cmp_pc_q;
    cmp_rd_d    = cmp_rd_q;
    cmp_data_d  = cmp_data_q;
    cmp_src_d   = cmp_src_q;
    rr_ptr_d    = rr_ptr_q;
    overflow_d  = overflow_q | ((|(req_valid & ~req_ready)) & ~flush);
    if (flush) begin
      cmp_valid_d = '0;
      cmp_pc_d    = '0;
      cmp_rd_d    = '0;
      cmp_data_d  = '0;
      cmp_src_d   = '0;
      rr_ptr_d    = '0;
    end else if (!hold) begin
      cmp_valid_d = slot_hit;
      cmp_pc_d    = '0;
      cmp_rd_d    = '0;
      cmp_data_d  = '0;
      cmp_src_d   = '0;
      for (int s = 0; s < NUM_SLOT; s++) begin
        if (slot_hit[s]) begin
          cmp_pc_d[s*32 +: 32]   = pc_mem_q[slot_src[s]][rd_ptr_q[slot_src[s]]];
          cmp_rd_d[s*6 +: 6]     = rd_mem_q[slot_src[s]][rd_ptr_q[slot_src[s]]];
          cmp_data_d[s*32 +: 32] = data_mem_q[slot_src[s]][rd_ptr_q[slot_src[s]]];
          cmp_src_d[s*2 +: 2]    = 2'(slot_src[s]);
        end
      end
      // Next scan starts just past the last winner so every unit gets a turn.
      if (|slot_hit) begin
        rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        for (int e = 0; e < DEPTH; e++) begin
          pc_mem_q[r][e]   <= '0;
          rd_mem_q[r][e]   <= '0;
          data_mem_q[r][e] <= '0;
        end
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        cnt_q[r]    <= '0;
      end
      rr_ptr_q    <= '0;
      cmp_valid_q <= '0;
      cmp_pc_q    <= '0;
      cmp_rd_q    <= '0;
      cmp_data_q  <= '0;
      cmp_src_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pc_mem_q    <= pc_mem_d;
      rd_mem_q    <= rd_mem_d;
      data_mem_q  <= data_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_pc_q    <= cmp_pc_d;
      cmp_rd_q    <= cmp_rd_d;
      cmp_data_q  <= cmp_data_d;
      cmp_src_q   <= cmp_src_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cmp_valid    = cmp_valid_q;
  assign cmp_pc       = cmp_pc_q;
  assign cmp_rd       = cmp_rd_q;
  assign cmp_data     = cmp_data_q;
  assign cmp_src      = cmp_src_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// tb_complete_arbiter
//   Directed stimulus for complete_arbiter. Expected completions are queued
//   as stimulus is driven and consumed by a monitor whenever a fresh slot
//   value appears; control/status outputs are checked inline.
module tb_complete_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int NUM_SLOT = 2;
  localparam int DEPTH    = 2;

  logic                   clk;
  logic                   rstn;
  logic                   flush;
  logic                   hold;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*32-1:0]  req_pc;
  logic [NUM_REQ*6-1:0]   req_rd;
  logic [NUM_REQ*32-1:0]  req_data;
  logic [NUM_SLOT-1:0]    cmp_valid;
  logic [NUM_SLOT*32-1:0] cmp_pc;
  logic [NUM_SLOT*6-1:0]  cmp_rd;
  logic [NUM_SLOT*32-1:0] cmp_data;
  logic [NUM_SLOT*2-1:0]  cmp_src;
  logic                   overflow_err;

  complete_arbiter #(
    .NUM_REQ (NUM_REQ),
    .NUM_SLOT(NUM_SLOT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .hold        (hold),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pc      (req_pc),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .cmp_valid   (cmp_valid),
    .cmp_pc      (cmp_pc),
    .cmp_rd      (cmp_rd),
    .cmp_data    (cmp_data),
    .cmp_src     (cmp_src),
    .overflow_err(overflow_err)
  );

  typedef struct {
    int          slot;
    int          src;
    logic [31:0] pc;
    logic [5:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   fresh = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input int r, input logic [31:0] pc, input logic [5:0] rd,
                     input logic [31:0] d);
    req_valid[r]        = 1'b1;
    req_pc[r*32 +: 32]  = pc;
    req_rd[r*6 +: 6]    = rd;
    req_data[r*32 +: 32] = d;
  endtask

  task automatic drvp(input int r, input logic [31:0] pc);
    drv(r, pc, pc[7:2], ~pc);
  endtask

  task automatic expc(input int slot, input int src, input logic [31:0] pc,
                      input logic [5:0] rd, input logic [31:0] d);
    exp_t e;
    e.slot = slot;
    e.src  = src;
    e.pc   = pc;
    e.rd   = rd;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic expp(input int slot, input int src, input logic [31:0] pc);
    expc(slot, src, pc, pc[7:2], ~pc);
  endtask

  task automatic idle_req();
    req_valid = '0;
  endtask

  // A slot value is new only if the preceding edge was allowed to load it.
  always @(posedge clk) fresh = rstn && !hold && !flush;

  always @(negedge clk) begin
    if (fresh) begin
      for (int s = 0; s < NUM_SLOT; s++) begin
        if (cmp_valid[s]) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected", {32'(s), cmp_pc[s*32 +: 32]}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            mon_e = sb_q.pop_front();
            chk("sb_slot", 64'(s), 64'(mon_e.slot));
            chk("sb_src", 64'(cmp_src[s*2 +: 2]), 64'(mon_e.src));
            chk("sb_pc", 64'(cmp_pc[s*32 +: 32]), 64'(mon_e.pc));
            chk("sb_rd", 64'(cmp_rd[s*6 +: 6]), 64'(mon_e.rd));
            chk("sb_data", 64'(cmp_data[s*32 +: 32]), 64'(mon_e.data));
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rstn      = 1'b0;
    flush     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_pc    = '0;
    req_rd    = '0;
    req_data  = '0;
    #12;
    chk("rst_cmp_valid", 64'(cmp_valid), 64'h0);
    chk("rst_cmp_pc", 64'(cmp_pc), 64'h0);
    chk("rst_cmp_src", 64'(cmp_src), 64'h0);
    chk("rst_ovf", 64'(overflow_err), 64'h0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    chk("rst_ready", 64'(req_ready), 64'hF);

    // single push from req 2: visible after the second edge, one cycle only
    drv(2, 32'h40, 6'd5, 32'hDEAD);
    expc(0, 2, 32'h40, 6'd5, 32'hDEAD);
    step(); idle_req();
    chk("t1_latency", 64'(cmp_valid), 64'h0);
    step();
    chk("t1_valid", 64'(cmp_valid), 64'h1);
    chk("t1_src", 64'(cmp_src[1:0]), 64'h2);
    step();
    chk("t1_clear", 64'(cmp_valid), 64'h0);

    // req 3 alone: rr pointer wraps back to 0
    drvp(3, 32'h44);
    expp(0, 3, 32'h44);
    step(); idle_req();
    step();
    chk("t1b_valid", 64'(cmp_valid), 64'h1);
    chk("t1b_src", 64'(cmp_src[1:0]), 64'h3);
    step();
    chk("t1b_clear", 64'(cmp_valid), 64'h0);

    // all four at once: {0,1} then {2,3}
    for (int r = 0; r < NUM_REQ; r++) drvp(r, 32'h10 + 32'(4 * r));
    expp(0, 0, 32'h10); expp(1, 1, 32'h14);
    expp(0, 2, 32'h18); expp(1, 3, 32'h1C);
    step(); idle_req();
    step();
    chk("t2_first", 64'(cmp_valid), 64'h3);
    step();
    chk("t2_second", 64'(cmp_valid), 64'h3);
    step();
    chk("t2_clear", 64'(cmp_valid), 64'h0);

    // back-pressure under continuous hold
    hold = 1'b1;
    drvp(3, 32'h300); expp(0, 3, 32'h300);
    step();
    chk("t3_ready_one", 64'(req_ready[3]), 64'h1);
    drvp(3, 32'h304); expp(0, 3, 32'h304);
    step();
    chk("t3_ready_full", 64'(req_ready[3]), 64'h0);
    chk("t3_ovf_clean", 64'(overflow_err), 64'h0);
    drvp(3, 32'h308);
    step(); idle_req();
    chk("t3_ovf_set", 64'(overflow_err), 64'h1);
    chk("t3_held_idle", 64'(cmp_valid), 64'h0);
    hold = 1'b0;
    step();
    chk("t3_out1", 64'(cmp_valid), 64'h1);
    step();
    chk("t3_out2", 64'(cmp_valid), 64'h1);
    chk("t3_ready_back", 64'(req_ready[3]), 64'h1);
    step();
    chk("t3_clear", 64'(cmp_valid), 64'h0);

    // hold during an active grant, then rotation from rr_ptr=2
    drvp(0, 32'h20); drvp(1, 32'h24);
    expp(0, 0, 32'h20); expp(1, 1, 32'h24);
    step(); idle_req();
    drvp(0, 32'h28); drvp(2, 32'h2C);
    expp(0, 2, 32'h2C); expp(1, 0, 32'h28);
    step(); idle_req();
    hold = 1'b1;
    chk("t4_valid", 64'(cmp_valid), 64'h3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_valid", 64'(cmp_valid), 64'h3);
      chk("t4_hold_pc", 64'(cmp_pc), {32'h24, 32'h20});
    end
    hold = 1'b0;
    step();
    chk("t4_next_valid", 64'(cmp_valid), 64'h3);
    chk("t4_next_src", 64'(cmp_src), 64'h2);
    step();
    chk("t4_clear", 64'(cmp_valid), 64'h0);

    // flush with full FIFOs and live outputs
    drvp(0, 32'h50); drvp(1, 32'h60); drvp(2, 32'h70); drvp(3, 32'h80);
    expp(0, 1, 32'h60); expp(1, 2, 32'h70);
    step(); idle_req();
    drvp(0, 32'h54); drvp(1, 32'h64);
    step(); idle_req();
    chk("t5_valid", 64'(cmp_valid), 64'h3);
    hold = 1'b1;
    drvp(1, 32'h68);
    step(); idle_req();
    chk("t5_ready_full", 64'(req_ready), 64'hC);
    chk("t5_held", 64'(cmp_valid), 64'h3);
    flush = 1'b1;
    drvp(2, 32'h99);
    step(); idle_req();
    flush = 1'b0;
    hold  = 1'b0;
    chk("t5_flush_valid", 64'(cmp_valid), 64'h0);
    chk("t5_flush_ready", 64'(req_ready), 64'hF);
    chk("t5_ovf_sticky", 64'(overflow_err), 64'h1);
    step();
    chk("t5_idle1", 64'(cmp_valid), 64'h0);
    step();
    chk("t5_idle2", 64'(cmp_valid), 64'h0);
    drvp(0, 32'hA0); drvp(2, 32'hA2); drvp(3, 32'hA3);
    expp(0, 0, 32'hA0); expp(1, 2, 32'hA2); expp(0, 3, 32'hA3);
    step(); idle_req();
    step();
    chk("t5_rr0_a", 64'(cmp_valid), 64'h3);
    step();
    chk("t5_rr0_b", 64'(cmp_valid), 64'h1);
    step();
    chk("t5_clear", 64'(cmp_valid), 64'h0);

    // asynchronous reset while busy
    for (int r = 0; r < NUM_REQ; r++) drvp(r, 32'hC0 + 32'(4 * r));
    expp(0, 0, 32'hC0); expp(1, 1, 32'hC4);
    step(); idle_req();
    step();
    chk("t6_busy", 64'(cmp_valid), 64'h3);
    #4;
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", 64'(cmp_valid), 64'h0);
    chk("t6_async_pc", 64'(cmp_pc), 64'h0);
    chk("t6_async_data", 64'(cmp_data), 64'h0);
    chk("t6_async_src", 64'(cmp_src), 64'h0);
    chk("t6_async_ovf", 64'(overflow_err), 64'h0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    chk("t6_ready", 64'(req_ready), 64'hF);
    drvp(1, 32'hB0);
    expp(0, 1, 32'hB0);
    step(); idle_req();
    chk("t6_latency", 64'(cmp_valid), 64'h0);
    step();
    chk("t6_valid", 64'(cmp_valid), 64'h1);
    chk("t6_pc", 64'(cmp_pc[31:0]), 64'hB0);
    step();
    chk("t6_clear", 64'(cmp_valid), 64'h0);

    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
